// File: rtl/rect_rasterizer_pkg.sv
// rect_rasterizer_pkg
//   Shared types and screen constants for the rectangle rasterizer.
//   - win_struct     : rectangle descriptor {rowstart, colstart, width, length}
//   - SCREEN_ROWS/COLS: screen geometry used as the rasterizer's default bounds
//   - raster_state_e : rasterizer FSM states
//   - clip_end       : 33-bit, non-wrapping min(start + size, limit)
package rect_rasterizer_pkg;

  localparam int SCREEN_ROWS = 480;
  localparam int SCREEN_COLS = 640;

  typedef struct packed {
    logic [31:0] rowstart;
    logic [31:0] colstart;
    logic [31:0] width;
    logic [31:0] length;
  } win_struct;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } raster_state_e;

  // Exclusive end of a span clipped to the screen. The sum is taken one bit
  // wider than the operands so that a huge size never wraps below start.
  function automatic logic [32:0] clip_end(input logic [31:0] start,
                                           input logic [31:0] size,
                                           input logic [32:0] limit);
    logic [32:0] sum_s;
    sum_s = {1'b0, start} + {1'b0, size};
    if (sum_s < limit) begin
      clip_end = sum_s;
    end else begin
      clip_end = limit;
    end
  endfunction

endpackage

// File: rtl/rect_rasterizer_span_counter.sv
// span_counter
//   Walks a half-open span [start, end). On load the bounds are latched and
//   the value jumps to start; on step the value advances by one, wrapping
//   back to start when it sits on the last element of the span.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   load        - latch start_val/end_val, value <= start_val
//   step        - advance (or wrap) the value
//   start_val   - first element of the span
//   end_val     - exclusive end of the span (33 bits, never wraps)
//   value       - current element
//   at_end      - value is the last element of the span
module span_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] start_val,
  input  logic [32:0] end_val,
  output logic [31:0] value,
  output logic        at_end
);

  logic [31:0] start_r;
  logic [32:0] end_r;
  logic [31:0] value_r;

  // Span bounds and running value: load takes priority over step.
  always_ff @(posedge clk) begin
    if (reset) begin
      start_r <= 32'd0;
      end_r   <= 33'd0;
      value_r <= 32'd0;
    end else if (load) begin
      start_r <= start_val;
      end_r   <= end_val;
      value_r <= start_val;
    end else if (step) begin
      if (at_end) begin
        value_r <= start_r;
      end else begin
        value_r <= value_r + 32'd1;
      end
    end
  end

  // Compared 33 bits wide so an end of 2**32 is still representable.
  assign at_end = (({1'b0, value_r} + 33'd1) >= end_r);
  assign value  = value_r;

endmodule

// File: rtl/rect_rasterizer.sv
// rect_rasterizer
//   Accepts one rectangle at a time and streams every covered, on-screen
//   pixel in raster order (row-major) towards the framebuffer writer.
//   A pixel (row, col) is covered when
//     rowstart <= row < rowstart + width  and  colstart <= col < colstart + length,
//   and it is emitted only if row < ROWS and col < COLS.
// Ports:
//   clk, reset  - clock, synchronous active-high reset
//   rect        - rectangle descriptor (win_struct)
//   rect_valid  - rect is valid;      rect_ready - block can accept a rect
//   pix_row/col - coordinates of the current pixel
//   pix_valid   - pixel is valid;     pix_ready  - downstream accepts pixel
//   pix_last    - current pixel is the last one of its rectangle
//   rect_done   - one-cycle pulse once a rectangle is fully emitted or discarded
module rect_rasterizer
  import rect_rasterizer_pkg::*;
#(
  parameter int ROWS = SCREEN_ROWS,
  parameter int COLS = SCREEN_COLS
) (
  input  logic        clk,
  input  logic        reset,
  input  win_struct   rect,
  input  logic        rect_valid,
  output logic        rect_ready,
  output logic [31:0] pix_row,
  output logic [31:0] pix_col,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_last,
  output logic        rect_done
);

  localparam logic [32:0] ROWS_L = 33'(ROWS);
  localparam logic [32:0] COLS_L = 33'(COLS);

  raster_state_e state_r;
  raster_state_e state_nxt_s;

  logic        rect_ready_r;
  logic        pix_valid_r;
  logic        rect_done_r;
  logic        rect_ready_nxt_s;
  logic        pix_valid_nxt_s;
  logic        rect_done_nxt_s;

  logic [32:0] row_end_s;
  logic [32:0] col_end_s;
  logic        empty_s;
  logic        accept_s;
  logic        xfer_s;
  logic        final_xfer_s;
  logic        load_s;
  logic        col_step_s;
  logic        row_step_s;
  logic [31:0] row_val_s;
  logic [31:0] col_val_s;
  logic        row_at_end_s;
  logic        col_at_end_s;

  assign row_end_s = clip_end(rect.rowstart, rect.width,  ROWS_L);
  assign col_end_s = clip_end(rect.colstart, rect.length, COLS_L);

  // A rectangle with nothing on screen is acknowledged without emitting.
  assign empty_s = (rect.width == 32'd0) || (rect.length == 32'd0) ||
                   ({1'b0, rect.rowstart} >= ROWS_L) ||
                   ({1'b0, rect.colstart} >= COLS_L);

  assign accept_s     = rect_valid && rect_ready_r && (state_r == ST_IDLE);
  assign xfer_s       = pix_valid_r && pix_ready;
  assign final_xfer_s = xfer_s && row_at_end_s && col_at_end_s;

  span_counter u_row_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .step      (row_step_s),
    .start_val (rect.rowstart),
    .end_val   (row_end_s),
    .value     (row_val_s),
    .at_end    (row_at_end_s)
  );

  span_counter u_col_cnt (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .step      (col_step_s),
    .start_val (rect.colstart),
    .end_val   (col_end_s),
    .value     (col_val_s),
    .at_end    (col_at_end_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !empty_s) begin
          state_nxt_s = ST_EMIT;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (final_xfer_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_EMIT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output / datapath-control decode; handshake outputs are registered below.
  always_comb begin
    load_s          = 1'b0;
    col_step_s      = 1'b0;
    row_step_s      = 1'b0;
    rect_done_nxt_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          load_s          = !empty_s;
          rect_done_nxt_s = empty_s;
        end else begin
          load_s          = 1'b0;
          rect_done_nxt_s = 1'b0;
        end
      end
      ST_EMIT: begin
        // The column counter wraps by itself; the row advances on that wrap.
        col_step_s      = xfer_s;
        row_step_s      = xfer_s && col_at_end_s;
        rect_done_nxt_s = final_xfer_s;
      end
      default: begin
        load_s          = 1'b0;
        rect_done_nxt_s = 1'b0;
      end
    endcase
    rect_ready_nxt_s = (state_nxt_s == ST_IDLE);
    pix_valid_nxt_s  = (state_nxt_s == ST_EMIT);
  end

  // Registered handshake outputs; rect_ready stays low while in reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rect_ready_r <= 1'b0;
      pix_valid_r  <= 1'b0;
      rect_done_r  <= 1'b0;
    end else begin
      rect_ready_r <= rect_ready_nxt_s;
      pix_valid_r  <= pix_valid_nxt_s;
      rect_done_r  <= rect_done_nxt_s;
    end
  end

  assign rect_ready = rect_ready_r;
  assign pix_valid  = pix_valid_r;
  assign rect_done  = rect_done_r;
  assign pix_row    = row_val_s;
  assign pix_col    = col_val_s;
  // Decoded purely from registers, so it is glitch-free and stable under stall.
  assign pix_last   = pix_valid_r && row_at_end_s && col_at_end_s;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Self-checking bench for rect_rasterizer: directed cases plus randomized
// rectangles and backpressure, compared against a nested-loop pixel model.
module tb_rect_rasterizer;
  import rect_rasterizer_pkg::*;

  localparam int ROWS = SCREEN_ROWS;
  localparam int COLS = SCREEN_COLS;

  logic        clk = 1'b0;
  logic        reset;
  win_struct   rect;
  logic        rect_valid;
  logic        rect_ready;
  logic [31:0] pix_row;
  logic [31:0] pix_col;
  logic        pix_valid;
  logic        pix_ready;
  logic        pix_last;
  logic        rect_done;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  rect_rasterizer dut (
    .clk        (clk),
    .reset      (reset),
    .rect       (rect),
    .rect_valid (rect_valid),
    .rect_ready (rect_ready),
    .pix_row    (pix_row),
    .pix_col    (pix_col),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .pix_last   (pix_last),
    .rect_done  (rect_done)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic win_struct mk(input logic [31:0] rs, input logic [31:0] cs,
                                   input logic [31:0] w, input logic [31:0] l);
    win_struct r;
    r.rowstart = rs;
    r.colstart = cs;
    r.width    = w;
    r.length   = l;
    return r;
  endfunction

  // Reference: every covered pixel that lies on screen, in raster order.
  task automatic build_expected(input win_struct r);
    longint rs, cs, re, ce;
    exp_q.delete();
    rs = r.rowstart;
    cs = r.colstart;
    re = rs + longint'(r.width);
    ce = cs + longint'(r.length);
    for (longint rr = rs; rr < re && rr < ROWS; rr++) begin
      for (longint cc = cs; cc < ce && cc < COLS; cc++) begin
        exp_q.push_back({rr[31:0], cc[31:0]});
      end
    end
  endtask

  // Present r until it is accepted; returns at the negedge after the accept edge.
  task automatic send_rect(input win_struct r);
    int n;
    n = 0;
    rect       = r;
    rect_valid = 1'b1;
    while (!rect_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("accept_timeout", (n < 50), 1'b1);
    @(negedge clk);
    rect_valid = 1'b0;
  endtask

  // mode 0: always ready, 1: ready pattern 1,0,0,1,..., 2: random ready.
  task automatic run_rect(input win_struct r, input int mode);
    logic [3:0] pat;
    logic [63:0] front;
    logic rdy;
    int k, cyc;
    pat = 4'b1001;
    build_expected(r);
    pix_ready = (mode == 0);
    send_rect(r);
    if (exp_q.size() == 0) begin
      check_eq("empty_valid", pix_valid, 1'b0);
      check_eq("empty_done", rect_done, 1'b1);
      @(negedge clk);
      check_eq("empty_done_pulse", rect_done, 1'b0);
      check_eq("empty_valid2", pix_valid, 1'b0);
    end else begin
      k = 0;
      cyc = 0;
      check_eq("first_valid", pix_valid, 1'b1);
      while (exp_q.size() > 0 && cyc < 2000) begin
        if (!pix_valid) begin
          check_eq("pix_valid_drop", pix_valid, 1'b1);
          break;
        end
        front = exp_q[0];
        check_eq("pix_row", pix_row, front[63:32]);
        check_eq("pix_col", pix_col, front[31:0]);
        check_eq("pix_last", pix_last, (exp_q.size() == 1));
        check_eq("done_early", rect_done, 1'b0);
        check_eq("ready_busy", rect_ready, 1'b0);
        if (mode == 0) rdy = 1'b1;
        else if (mode == 1) rdy = pat[k % 4];
        else rdy = 1'($urandom_range(0, 1));
        k++;
        pix_ready = rdy;
        if (rdy) void'(exp_q.pop_front());
        @(negedge clk);
        cyc++;
      end
      check_eq("emit_timeout", (cyc < 2000), 1'b1);
      check_eq("end_valid", pix_valid, 1'b0);
      check_eq("end_done", rect_done, 1'b1);
      check_eq("end_ready", rect_ready, 1'b1);
      @(negedge clk);
      check_eq("end_done_pulse", rect_done, 1'b0);
    end
  endtask

  initial begin
    win_struct r;
    int n;
    reset      = 1'b1;
    rect_valid = 1'b0;
    pix_ready  = 1'b0;
    rect       = '0;
    repeat (3) @(negedge clk);
    check_eq("rst_ready", rect_ready, 1'b0);
    check_eq("rst_valid", pix_valid, 1'b0);
    check_eq("rst_last", pix_last, 1'b0);
    check_eq("rst_done", rect_done, 1'b0);
    check_eq("rst_row", pix_row, 32'd0);
    check_eq("rst_col", pix_col, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_rst_ready", rect_ready, 1'b1);

    // Basic raster, backpressure and clipping.
    run_rect(mk(32'd10, 32'd20, 32'd2, 32'd3), 0);
    run_rect(mk(32'd10, 32'd20, 32'd2, 32'd3), 1);
    run_rect(mk(32'd478, 32'd638, 32'd10, 32'd10), 0);
    run_rect(mk(32'd478, 32'd638, 32'd10, 32'd10), 2);
    run_rect(mk(32'd500, 32'd0, 32'd5, 32'd5), 0);
    run_rect(mk(32'd0, 32'd640, 32'd5, 32'd5), 0);
    run_rect(mk(32'd100, 32'd155, 32'd0, 32'd10), 0);
    run_rect(mk(32'd100, 32'd155, 32'd180, 32'd0), 0);
    // Sizes whose 32-bit sum would wrap must still clip to the screen edge.
    run_rect(mk(32'd475, 32'd635, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 0);
    run_rect(mk(32'hFFFF_FFFE, 32'd0, 32'd5, 32'd5), 0);
    run_rect(mk(32'd479, 32'd639, 32'd1, 32'd1), 1);

    // Back-to-back rectangles with rect_valid held high.
    pix_ready  = 1'b1;
    rect       = mk(32'd0, 32'd0, 32'd1, 32'd2);
    rect_valid = 1'b1;
    n = 0;
    while (!rect_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("b2b_accept", (n < 50), 1'b1);
    @(negedge clk);
    rect = mk(32'd5, 32'd5, 32'd1, 32'd1);
    check_eq("b2b_v0", pix_valid, 1'b1);
    check_eq("b2b_r0", pix_row, 32'd0);
    check_eq("b2b_c0", pix_col, 32'd0);
    check_eq("b2b_l0", pix_last, 1'b0);
    @(negedge clk);
    check_eq("b2b_v1", pix_valid, 1'b1);
    check_eq("b2b_c1", pix_col, 32'd1);
    check_eq("b2b_l1", pix_last, 1'b1);
    @(negedge clk);
    check_eq("b2b_bubble_valid", pix_valid, 1'b0);
    check_eq("b2b_bubble_ready", rect_ready, 1'b1);
    check_eq("b2b_done1", rect_done, 1'b1);
    @(negedge clk);
    rect_valid = 1'b0;
    check_eq("b2b_v2", pix_valid, 1'b1);
    check_eq("b2b_r2", pix_row, 32'd5);
    check_eq("b2b_c2", pix_col, 32'd5);
    check_eq("b2b_l2", pix_last, 1'b1);
    check_eq("b2b_done_gap", rect_done, 1'b0);
    @(negedge clk);
    check_eq("b2b_v3", pix_valid, 1'b0);
    check_eq("b2b_done2", rect_done, 1'b1);
    @(negedge clk);
    check_eq("b2b_done_pulse", rect_done, 1'b0);

    // Reset while the third pixel of {10,20,2,3} is on the bus.
    pix_ready = 1'b1;
    send_rect(mk(32'd10, 32'd20, 32'd2, 32'd3));
    @(negedge clk);
    @(negedge clk);
    check_eq("mid_col", pix_col, 32'd22);
    check_eq("mid_valid", pix_valid, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    check_eq("mid_rst_valid", pix_valid, 1'b0);
    check_eq("mid_rst_done", rect_done, 1'b0);
    check_eq("mid_rst_ready", rect_ready, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("mid_rel_ready", rect_ready, 1'b1);
    check_eq("mid_rel_valid", pix_valid, 1'b0);
    check_eq("mid_rel_done", rect_done, 1'b0);
    @(negedge clk);
    check_eq("mid_rel_done2", rect_done, 1'b0);

    // Randomized rectangles, biased towards the screen edges.
    for (int i = 0; i < 40; i++) begin
      r.rowstart = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(ROWS - 4, ROWS + 1))
                                               : 32'($urandom_range(0, ROWS - 1));
      r.colstart = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(COLS - 4, COLS + 1))
                                               : 32'($urandom_range(0, COLS - 1));
      r.width    = 32'($urandom_range(0, 5));
      r.length   = 32'($urandom_range(0, 6));
      run_rect(r, int'($urandom_range(0, 2)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_rasterizer.md
Name: rect_rasterizer

Overview:
- Sequential producer that takes one win_struct rectangle at a time and emits every covered screen pixel as a (row, col) stream, raster order.
- Output feeds the framebuffer write port, so rectangles are drawn into memory rather than hit-tested per pixel in combinational logic.
- Inclusion rule matches the pixel hit-test exactly:
  - rowstart <= row < rowstart+width
  - colstart <= col < colstart+length
- Sits between the rectangle table (win/maze factories) and the framebuffer writer.

Parameters:
ROWS, 480, screen height; rows >= ROWS are clipped
COLS, 640, screen width; cols >= COLS are clipped

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
rect  input  win_struct  rectangle {rowstart, colstart, width, length}
rect_valid  input  1  rect is valid
rect_ready  output  1  block can accept a rectangle
pix_row  output  32  row of current pixel
pix_col  output  32  column of current pixel
pix_valid  output  1  pixel is valid
pix_ready  input  1  downstream accepts pixel
pix_last  output  1  current pixel is last of its rectangle
rect_done  output  1  one-cycle pulse: rectangle fully emitted or discarded

Behaviour:
- Reset: state IDLE; rect_ready=0 during reset, 1 on first cycle after; pix_valid=0, pix_last=0, rect_done=0, pix_row=0, pix_col=0.
- Reset mid-rectangle: abandons it; no further pixels; no rect_done.
- Handshakes: rect accepted when rect_valid && rect_ready; pixel transferred when pix_valid && pix_ready.
- FSM states: IDLE, EMIT.
- IDLE:
  - rect_ready=1, pix_valid=0.
  - On accept, latch row_end=min(rowstart+width, ROWS) and col_end=min(colstart+length, COLS).
  - Sums are computed 33 bits wide, no wrap.
  - Empty case: width==0, length==0, rowstart>=ROWS or colstart>=COLS.
    - Stay IDLE; rect_done=1 next cycle; no pixels.
  - Otherwise:
    - pix_row=rowstart, pix_col=colstart; go to EMIT.
    - First pix_valid is in the cycle after accept (latency 1).
- EMIT:
  - rect_ready=0, pix_valid=1.
  - While !pix_ready, pix_row, pix_col and pix_last hold stable.
  - On transfer:
    - If col+1 < col_end: col++.
    - Else if row+1 < row_end: row++, col=colstart.
    - Else: go to IDLE, rect_done=1 next cycle.
  - pix_last=1 exactly when row==row_end-1 && col==col_end-1.
- Throughput: 1 pixel/cycle under no backpressure. One idle cycle between rectangles, since rect_ready is only high in IDLE.
- rect_done is registered and pulses exactly once per accepted rectangle, empty or not. It may coincide with rect_ready=1 and a new accept.
- Pixel count per rectangle: (row_end-rowstart)*(col_end-colstart). Never emits row>=ROWS or col>=COLS.

Decomposition:
- win_struct already lives in the shared types file; add ROWS/COLS screen constants there, overriding the parameters' defaults.
- One natural sub-module: span_counter (start, end, step enable → value, at_end), instanced for row and col.
- FSM stays in the top.

Test Plan:
- Basic raster, pix_ready=1:
  - rect {10,20,2,3} → 6 pixels: (10,20),(10,21),(10,22),(11,20),(11,21),(11,22).
  - pix_last only on (11,22).
  - rect_done one cycle after last transfer.
  - First pix_valid 1 cycle after accept.
- Backpressure:
  - Same rect, pix_ready toggled 1,0,0,1,… → identical 6-pixel sequence.
  - Outputs stable while pix_ready=0.
  - No duplicated or dropped pixels.
- Clipping:
  - rect {478,638,10,10} → exactly 4 pixels (478,638),(478,639),(479,638),(479,639), then rect_done.
  - rect {500,0,5,5} → 0 pixels, rect_done one cycle after accept.
- Zero size: rect {100,155,0,10} and {100,155,180,0} → no pix_valid, one rect_done pulse each.
- Back-to-back rectangles:
  - rect_valid held high with {0,0,1,2} then {5,5,1,1} → pixels (0,0),(0,1), one bubble cycle, then (5,5).
  - Two rect_done pulses.
- Reset mid-operation: reset asserted during 3rd pixel of {10,20,2,3} → next cycle pix_valid=0, no rect_done, rect_ready=1 after reset release.
